// File: rtl/pipe_irq_ctrl.sv
// Vectored, prioritised interrupt controller for the 5-stage MIPS pipeline.
// Each IRQ lane synchronises and edge-latches its request; the top arbitrates and keeps the EPC/cause stack.

module pipe_irq_lane #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq,
    input  logic clr,
    output logic pending
);
    // sync_q[SYNC_STAGES] holds the previous synchronised value for edge detection
    logic [SYNC_STAGES:0] sync_q;
    logic                 rise;

    assign rise = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            pending <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-1:0], irq};
            // a fresh edge wins over a same-cycle clear
            pending <= (pending & ~clr) | rise;
        end
    end
endmodule

module pipe_irq_ctrl #(
    parameter int                N_IRQ       = 4,
    parameter int                ADDR_W      = 32,
    parameter int                SYNC_STAGES = 2,
    parameter int                NEST_DEPTH  = 1,
    parameter logic [ADDR_W-1:0] VEC_BASE    = 32'h0000_0004,
    parameter int                VEC_SHIFT   = 3,
    localparam int               IDX_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1,
    localparam int               DEPTH_W     = $clog2(NEST_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_IRQ-1:0]   irq_in,
    input  logic [N_IRQ-1:0]   irq_mask,
    input  logic               ie_global,
    input  logic               stall_in,
    input  logic               eret_in,
    input  logic               exe_valid,
    input  logic [ADDR_W-1:0]  exe_pc,
    input  logic [ADDR_W-1:0]  id_pc,
    output logic               flush_ie,
    output logic               flush_id,
    output logic               redirect_en,
    output logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  epc_out,
    output logic [IDX_W-1:0]   cause_out,
    output logic               ir_en,
    output logic [DEPTH_W-1:0] depth_out,
    output logic               eret_err
);
    logic [N_IRQ-1:0]   pending, eligible, clr;
    logic [IDX_W-1:0]   win, top_cause;
    logic [ADDR_W-1:0]  top_epc;
    logic [DEPTH_W-1:0] sp;
    logic               sp_open, take, eret_ok;
    logic [ADDR_W-1:0]  epc_stk   [NEST_DEPTH];
    logic [IDX_W-1:0]   cause_stk [NEST_DEPTH];

    for (genvar g = 0; g < N_IRQ; g++) begin : g_lane
        pipe_irq_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .irq     (irq_in[g]),
            .clr     (clr[g]),
            .pending (pending[g])
        );
    end

    always_comb begin
        top_epc   = '0;
        top_cause = '0;
        for (int k = 0; k < NEST_DEPTH; k++)
            if (sp == DEPTH_W'(k + 1)) begin
                top_epc   = epc_stk[k];
                top_cause = cause_stk[k];
            end
    end

    always_comb begin
        win = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (eligible[i]) win = IDX_W'(i);
    end

    assign eligible = ie_global ? (pending & irq_mask) : '0;
    assign sp_open  = sp < DEPTH_W'(NEST_DEPTH);
    // only a strictly higher-priority source may preempt a running handler; ERET wins ties
    assign take     = !rst && ie_global && sp_open && (|eligible) && !stall_in && !eret_in &&
                      (sp == '0 || win < top_cause);
    assign eret_ok  = !rst && eret_in && sp != '0;
    assign clr      = take ? (N_IRQ'(1) << win) : '0;

    assign ir_en       = ie_global && (rst || sp_open);
    assign flush_ie    = take;
    assign flush_id    = eret_ok;
    assign redirect_en = take || eret_ok;
    assign redirect_pc = take    ? VEC_BASE + (ADDR_W'(win) << VEC_SHIFT) :
                         eret_ok ? top_epc : '0;
    assign eret_err    = !rst && eret_in && sp == '0;
    assign epc_out     = rst ? '0 : top_epc;
    assign cause_out   = rst ? '0 : top_cause;
    assign depth_out   = rst ? '0 : sp;

    always_ff @(posedge clk) begin
        if (rst)          sp <= '0;
        else if (take)    sp <= sp + DEPTH_W'(1);
        else if (eret_ok) sp <= sp - DEPTH_W'(1);
    end

    // interrupted EXE instruction re-executes on return; fall back to ID when EXE is a bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NEST_DEPTH; k++) begin
                epc_stk[k]   <= '0;
                cause_stk[k] <= '0;
            end
        end else if (take) begin
            for (int k = 0; k < NEST_DEPTH; k++)
                if (sp == DEPTH_W'(k)) begin
                    epc_stk[k]   <= exe_valid ? exe_pc : id_pc;
                    cause_stk[k] <= win;
                end
        end
    end
endmodule

// File: tb/tb_pipe_irq_ctrl.sv
// Bench for pipe_irq_ctrl: one instance without nesting and one with NEST_DEPTH=2, both driven
// from the same inputs and checked against a behavioural model, a directed table and corner sequences.

module tb_pipe_irq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_in, irq_mask;
    logic        ie_global, stall_in, eret_in, exe_valid;
    logic [31:0] exe_pc, id_pc;

    logic        fie1, fid1, ren1, ir1, err1, fie2, fid2, ren2, ir2, err2;
    logic [31:0] rpc1, epc1, rpc2, epc2;
    logic [1:0]  cause1, cause2, dep2;
    logic [0:0]  dep1;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    pipe_irq_ctrl #(.NEST_DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask), .ie_global(ie_global),
        .stall_in(stall_in), .eret_in(eret_in), .exe_valid(exe_valid), .exe_pc(exe_pc),
        .id_pc(id_pc), .flush_ie(fie1), .flush_id(fid1), .redirect_en(ren1),
        .redirect_pc(rpc1), .epc_out(epc1), .cause_out(cause1), .ir_en(ir1),
        .depth_out(dep1), .eret_err(err1));

    pipe_irq_ctrl #(.NEST_DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .irq_in(irq_in), .irq_mask(irq_mask), .ie_global(ie_global),
        .stall_in(stall_in), .eret_in(eret_in), .exe_valid(exe_valid), .exe_pc(exe_pc),
        .id_pc(id_pc), .flush_ie(fie2), .flush_id(fid2), .redirect_en(ren2),
        .redirect_pc(rpc2), .epc_out(epc2), .cause_out(cause2), .ir_en(ir2),
        .depth_out(dep2), .eret_err(err2));

    // ---------------- reference model ----------------
    // hist[k] = irq_in sampled k+1 edges ago; a request appears as pending 3 edges after it rises
    bit   [3:0]  hist   [3];
    bit   [3:0]  m_pend [2];
    int          m_sp   [2];
    logic [31:0] m_epc  [2][4];
    int          m_cause[2][4];
    int          m_depth[2];

    typedef struct {
        bit fie, fid, ren, iren, err, take, eok;
        logic [31:0] rpc, epc;
        int cause, depth, win;
    } exp_t;

    function automatic exp_t predict(int d);
        exp_t e;
        bit [3:0] el;
        e = '{default: 0};
        e.iren = ie_global;
        if (rst) return e;
        el = ie_global ? (m_pend[d] & irq_mask) : 4'h0;
        e.win = -1;
        for (int i = 3; i >= 0; i--) if (el[i]) e.win = i;
        e.depth = m_sp[d];
        if (m_sp[d] > 0) begin
            e.epc   = m_epc[d][m_sp[d]-1];
            e.cause = m_cause[d][m_sp[d]-1];
        end
        e.iren = ie_global && (m_sp[d] < m_depth[d]);
        e.take = e.iren && e.win >= 0 && !stall_in && !eret_in && (m_sp[d] == 0 || e.win < e.cause);
        e.eok  = eret_in && m_sp[d] > 0;
        e.err  = eret_in && m_sp[d] == 0;
        e.fie  = e.take;
        e.fid  = e.eok;
        e.ren  = e.take || e.eok;
        e.rpc  = e.take ? 32'h4 + 32'(e.win * 8) : e.epc;
        return e;
    endfunction

    task automatic model_update();
        exp_t e;
        bit [3:0] rise, m;
        rise = hist[1] & ~hist[2];
        if (rst) begin
            for (int k = 0; k < 3; k++) hist[k] = 4'h0;
            for (int d = 0; d < 2; d++) begin m_pend[d] = 4'h0; m_sp[d] = 0; end
            return;
        end
        for (int d = 0; d < 2; d++) begin
            e = predict(d);
            m = 4'h0;
            if (e.take) begin
                m = 4'b0001 << e.win;
                m_epc[d][m_sp[d]]   = exe_valid ? exe_pc : id_pc;
                m_cause[d][m_sp[d]] = e.win;
                m_sp[d]++;
            end else if (e.eok) m_sp[d]--;
            m_pend[d] = (m_pend[d] & ~m) | rise;
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = irq_in;
    endtask

    // ---------------- checking ----------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_out(string p, exp_t e, logic fie, logic fid, logic ren, logic [31:0] rpc,
                           logic [31:0] epc, logic [1:0] cause, logic [1:0] dep, logic iren, logic err);
        chk({p, ".flush_ie"}, fie, e.fie);
        chk({p, ".flush_id"}, fid, e.fid);
        chk({p, ".redirect_en"}, ren, e.ren);
        if (e.ren) chk({p, ".redirect_pc"}, rpc, e.rpc);
        chk({p, ".epc_out"}, epc, e.epc);
        chk({p, ".cause_out"}, cause, 32'(e.cause));
        chk({p, ".depth_out"}, dep, 32'(e.depth));
        chk({p, ".ir_en"}, iren, e.iren);
        chk({p, ".eret_err"}, err, e.err);
    endtask

    task automatic half_a();
        @(negedge clk);
        chk_out("m1", predict(0), fie1, fid1, ren1, rpc1, epc1, cause1, {1'b0, dep1}, ir1, err1);
        chk_out("m2", predict(1), fie2, fid2, ren2, rpc2, epc2, cause2, dep2, ir2, err2);
    endtask

    task automatic half_b();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        half_a();
        half_b();
    endtask

    // ---------------- directed table (dut1) ----------------
    typedef struct {
        logic [3:0] irq; bit st, er, xv; logic [31:0] xpc;
        bit ren; logic [31:0] rpc; bit fie, fid; logic [31:0] epc; int cause; bit iren; int dep; bit err;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t V(logic [3:0] irq, bit st, bit er, bit xv, logic [31:0] xpc,
                               bit ren, logic [31:0] rpc, bit fie, bit fid, logic [31:0] epc,
                               int cause, bit iren, int dep, bit err);
        vec_t v;
        v = '{irq, st, er, xv, xpc, ren, rpc, fie, fid, epc, cause, iren, dep, err};
        return v;
    endfunction

    initial begin
        m_depth[0] = 1;
        m_depth[1] = 2;
        rst = 1'b1; irq_in = 4'h0; irq_mask = 4'hF; ie_global = 1'b1; stall_in = 1'b0;
        eret_in = 1'b0; exe_valid = 1'b1; exe_pc = 32'h40; id_pc = 32'h3C;
        #1;
        step(); step();
        rst = 1'b0;

        //            irq  st er xv xpc      ren rpc     fie fid epc     c  ir dep err
        tbl.push_back(V(4'h0,0,0,1,32'h40,   0,32'h0,  0,0,32'h0,  0,1,0,0));
        tbl.push_back(V(4'h4,0,0,1,32'h40,   0,32'h0,  0,0,32'h0,  0,1,0,0));
        tbl.push_back(V(4'h4,0,0,1,32'h40,   0,32'h0,  0,0,32'h0,  0,1,0,0));
        tbl.push_back(V(4'h4,0,0,1,32'h40,   0,32'h0,  0,0,32'h0,  0,1,0,0));
        tbl.push_back(V(4'h4,0,0,1,32'h40,   1,32'h14, 1,0,32'h0,  0,1,0,0));
        tbl.push_back(V(4'h4,0,0,1,32'h14,   0,32'h0,  0,0,32'h40, 2,0,1,0));
        tbl.push_back(V(4'h4,0,1,1,32'h14,   1,32'h40, 0,1,32'h40, 2,0,1,0));
        tbl.push_back(V(4'h4,0,0,1,32'h40,   0,32'h0,  0,0,32'h0,  0,1,0,0));
        tbl.push_back(V(4'h4,0,1,1,32'h40,   0,32'h0,  0,0,32'h0,  0,1,0,1));
        tbl.push_back(V(4'h0,0,0,1,32'h40,   0,32'h0,  0,0,32'h0,  0,1,0,0));
        tbl.push_back(V(4'h1,1,0,1,32'h40,   0,32'h0,  0,0,32'h0,  0,1,0,0));
        tbl.push_back(V(4'h1,1,0,1,32'h40,   0,32'h0,  0,0,32'h0,  0,1,0,0));
        tbl.push_back(V(4'h1,1,0,1,32'h40,   0,32'h0,  0,0,32'h0,  0,1,0,0));
        tbl.push_back(V(4'h1,1,0,1,32'h40,   0,32'h0,  0,0,32'h0,  0,1,0,0));
        tbl.push_back(V(4'h1,1,0,1,32'h40,   0,32'h0,  0,0,32'h0,  0,1,0,0));
        tbl.push_back(V(4'h1,0,0,0,32'h40,   1,32'h4,  1,0,32'h0,  0,1,0,0));
        tbl.push_back(V(4'h1,0,0,1,32'h40,   0,32'h0,  0,0,32'h3C, 0,0,1,0));
        tbl.push_back(V(4'h1,0,1,1,32'h40,   1,32'h3C, 0,1,32'h3C, 0,0,1,0));
        tbl.push_back(V(4'h1,0,0,1,32'h40,   0,32'h0,  0,0,32'h0,  0,1,0,0));

        foreach (tbl[i]) begin
            irq_in = tbl[i].irq; stall_in = tbl[i].st; eret_in = tbl[i].er;
            exe_valid = tbl[i].xv; exe_pc = tbl[i].xpc;
            half_a();
            chk($sformatf("t%0d.redirect_en", i), ren1, tbl[i].ren);
            if (tbl[i].ren) chk($sformatf("t%0d.redirect_pc", i), rpc1, tbl[i].rpc);
            chk($sformatf("t%0d.flush_ie", i), fie1, tbl[i].fie);
            chk($sformatf("t%0d.flush_id", i), fid1, tbl[i].fid);
            chk($sformatf("t%0d.epc_out", i), epc1, tbl[i].epc);
            chk($sformatf("t%0d.cause_out", i), cause1, 32'(tbl[i].cause));
            chk($sformatf("t%0d.ir_en", i), ir1, tbl[i].iren);
            chk($sformatf("t%0d.depth_out", i), dep1, 32'(tbl[i].dep));
            chk($sformatf("t%0d.eret_err", i), err1, tbl[i].err);
            half_b();
        end

        // simultaneous irq1/irq3: idx1 first, idx3 after return
        irq_in = 4'b1011; exe_pc = 32'h40;
        repeat (3) step();
        half_a(); chk("p3.first", ren1, 1); chk("p3.first_pc", rpc1, 32'h0C); half_b();
        step();
        eret_in = 1'b1;
        half_a(); chk("p3.eret_pc", rpc1, 32'h40); half_b();
        eret_in = 1'b0;
        half_a(); chk("p3.second", ren1, 1); chk("p3.second_pc", rpc1, 32'h1C); half_b();
        eret_in = 1'b1; step(); eret_in = 1'b0;

        // nesting on dut2: idx0 preempts idx2, idx3 waits, LIFO returns
        irq_in = 4'h0;
        repeat (3) step();
        irq_in = 4'b0100; exe_pc = 32'h100;
        repeat (3) step();
        half_a(); chk("n.take2", ren2, 1); chk("n.take2_pc", rpc2, 32'h14); half_b();
        irq_in = 4'b1101; exe_pc = 32'h200;
        repeat (3) step();
        half_a(); chk("n.preempt", ren2, 1); chk("n.preempt_pc", rpc2, 32'h04); half_b();
        half_a(); chk("n.depth2", dep2, 2); chk("n.ir_en_full", ir2, 0); half_b();
        eret_in = 1'b1;
        half_a(); chk("n.eret1_pc", rpc2, 32'h200); half_b();
        eret_in = 1'b0;
        half_a(); chk("n.no_preempt", ren2, 0); chk("n.depth1", dep2, 1); half_b();
        eret_in = 1'b1;
        half_a(); chk("n.eret2_pc", rpc2, 32'h100); half_b();
        eret_in = 1'b0;
        half_a(); chk("n.take3", ren2, 1); chk("n.take3_pc", rpc2, 32'h1C); half_b();
        eret_in = 1'b1; step(); eret_in = 1'b0;

        // masked source stays pending, then reset in ISR wipes everything
        irq_in = 4'h0;
        repeat (3) step();
        irq_in = 4'b1110; irq_mask = 4'b0010;
        repeat (3) step();
        half_a(); chk("m.take1_pc", rpc1, 32'h0C); half_b();
        eret_in = 1'b1; step(); eret_in = 1'b0;
        half_a(); chk("m.masked", ren1, 0); half_b();
        irq_mask = 4'b0110;
        half_a(); chk("m.unmasked", ren1, 1); chk("m.unmasked_pc", rpc1, 32'h14); half_b();
        rst = 1'b1; irq_in = 4'h0; irq_mask = 4'hF;
        half_a(); chk("r.redirect", ren1, 0); chk("r.ir_en", ir1, 1); half_b();
        rst = 1'b0;
        repeat (5) begin
            half_a(); chk("r.no_take1", ren1, 0); chk("r.no_take2", ren2, 0); chk("r.depth", dep1, 0);
            half_b();
        end

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) irq_in[b] = ~irq_in[b];
            if ($urandom_range(0, 19) == 0) irq_mask = 4'($urandom);
            if ($urandom_range(0, 29) == 0) ie_global = ($urandom_range(0, 3) != 0);
            stall_in  = ($urandom_range(0, 3) == 0);
            eret_in   = ($urandom_range(0, 7) == 0);
            exe_valid = ($urandom_range(0, 3) != 0);
            exe_pc    = $urandom & 32'hFFFF_FFFC;
            id_pc     = $urandom & 32'hFFFF_FFFC;
            rst       = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
